// File: rtl/pipe_mult_param.sv
// Pipelined shift-add multiplier: each stage retires WIDTH/STAGES multiplier bits, carrying
// the partial sum, operands, signedness and tag along with a valid-ready handshake.
module pipe_mult_param #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned STAGES = 4,
  parameter int unsigned TAG_W  = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic               in_signed,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_product,
  output logic [TAG_W-1:0]   out_tag
);

  localparam int unsigned BITS = WIDTH / STAGES;
  localparam int unsigned PW   = 2 * WIDTH;

  logic              stall;
  logic [STAGES-1:0] vld_q, sgn_q;
  logic [PW-1:0]     sum_q [STAGES];
  logic [PW-1:0]     a_q   [STAGES];
  logic [WIDTH-1:0]  b_q   [STAGES];
  logic [TAG_W-1:0]  tag_q [STAGES];

  // Values presented to each stage: the ports for stage 0, the previous register otherwise.
  logic [STAGES-1:0] vld_in, sgn_in;
  logic [PW-1:0]     sum_in [STAGES];
  logic [PW-1:0]     a_in   [STAGES];
  logic [WIDTH-1:0]  b_in   [STAGES];
  logic [TAG_W-1:0]  tag_in [STAGES];
  logic [PW-1:0]     sum_d  [STAGES];
  logic [WIDTH-1:0]  b_d    [STAGES];

  assign stall    = vld_q[STAGES-1] & ~out_ready;
  // Reset forces ready high so a stale stall cannot block the cycle that clears it.
  assign in_ready = rst | ~stall;

  assign out_valid   = vld_q[STAGES-1];
  assign out_product = sum_q[STAGES-1];
  assign out_tag     = tag_q[STAGES-1];

  always_comb begin : stage_inputs
    vld_in[0] = in_valid & in_ready;
    sgn_in[0] = in_signed;
    sum_in[0] = '0;
    a_in[0]   = in_signed ? {{WIDTH{in_a[WIDTH-1]}}, in_a} : {{WIDTH{1'b0}}, in_a};
    b_in[0]   = in_b;
    tag_in[0] = in_tag;
    for (int unsigned s = 1; s < STAGES; s++) begin
      vld_in[s] = vld_q[s-1];
      sgn_in[s] = sgn_q[s-1];
      sum_in[s] = sum_q[s-1];
      a_in[s]   = a_q[s-1];
      b_in[s]   = b_q[s-1];
      tag_in[s] = tag_q[s-1];
    end
  end

  always_comb begin : shift_add
    logic [PW-1:0] acc;
    for (int unsigned s = 0; s < STAGES; s++) begin
      acc = sum_in[s];
      for (int unsigned j = 0; j < BITS; j++) begin
        if (b_in[s][j]) begin
          // In signed mode the multiplier MSB carries negative weight.
          if (sgn_in[s] && (s * BITS + j == WIDTH - 1)) begin
            acc = acc - (a_in[s] << (s * BITS + j));
          end else begin
            acc = acc + (a_in[s] << (s * BITS + j));
          end
        end
      end
      sum_d[s] = acc;
      b_d[s]   = b_in[s] >> BITS;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      sgn_q <= '0;
      for (int unsigned s = 0; s < STAGES; s++) begin
        sum_q[s] <= '0;
        a_q[s]   <= '0;
        b_q[s]   <= '0;
        tag_q[s] <= '0;
      end
    end else if (!stall) begin
      vld_q <= vld_in;
      for (int unsigned s = 0; s < STAGES; s++) begin
        if (vld_in[s]) begin
          sum_q[s] <= sum_d[s];
          a_q[s]   <= a_in[s];
          b_q[s]   <= b_d[s];
          sgn_q[s] <= sgn_in[s];
          tag_q[s] <= tag_in[s];
        end
      end
    end
  end

endmodule

// File: doc/pipe_mult_param.md
PIPE_MULT_PARAM -- requirements
Module: pipe_mult_param

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand width in bits; legal range 4..32.
REQ-002 SHALL have parameter STAGES, default 4, pipeline depth; legal range 1..WIDTH, WIDTH % STAGES == 0.
REQ-003 SHALL have parameter TAG_W, default 4, width of the sideband tag carried with each operation.
REQ-004 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1, reset; synchronous and active-high.
REQ-006 SHALL have port in_valid, input, 1, operand pair present.
REQ-007 SHALL have port in_ready, output, 1, block accepts operands this cycle.
REQ-008 SHALL have port in_a, input, WIDTH, multiplicand.
REQ-009 SHALL have port in_b, input, WIDTH, multiplier.
REQ-010 SHALL have port in_signed, input, 1, 1 = two's-complement operands, 0 = unsigned; latched per operation.
REQ-011 SHALL have port in_tag, input, TAG_W, opaque sideband returned with the result.
REQ-012 SHALL have port out_valid, output, 1, result present.
REQ-013 SHALL have port out_ready, input, 1, consumer accepts result this cycle.
REQ-014 SHALL have port out_product, output, 2*WIDTH, full-precision product.
REQ-015 SHALL have port out_tag, output, TAG_W, tag of the operation on out_product.

Function
REQ-016 SHALL accept an operation on a cycle where in_valid && in_ready; otherwise it SHALL capture nothing.
REQ-017 SHALL retire bits of in_b over STAGES stages: shift-add of WIDTH/STAGES multiplier bits per stage; each stage holds a valid bit, partial sum, remaining operand bits, signed flag and tag.
REQ-018 SHALL produce a result STAGES cycles after acceptance when not stalled (STAGES=4: accepted at cycle N, out_valid at N+4).
REQ-019 SHALL sustain one accepted operation per cycle when out_ready stays high.
REQ-020 SHALL define stall = out_valid && !out_ready; during stall every stage register SHALL hold and in_ready SHALL be 0.
REQ-021 SHALL drive in_ready = !stall combinationally (no dependency on in_valid).
REQ-022 SHALL hold out_product and out_tag stable while out_valid && !out_ready.
REQ-023 SHALL let bubbles advance: a stage whose valid bit is 0 imposes no stall.
REQ-024 SHALL compute the exact 2*WIDTH-bit product, no truncation or saturation; signed mode per two's-complement with sign-extended operands; unsigned mode zero-extended.
REQ-025 SHALL carry in_signed with each operation so that mixed signed/unsigned operations in flight are individually correct.
REQ-026 SHALL return out_tag equal to the in_tag captured with the same operation; results SHALL emerge in acceptance order.
REQ-027 SHALL, when a result is consumed and a new operation accepted on the same cycle, do both (no lost or duplicated operations).
REQ-028 SHALL, for STAGES=1, register the product once (latency 1) with the same handshake rules.

Reset
REQ-029 SHALL, while rst is high at a clock edge, clear all stage valid bits; out_valid = 0, out_product = 0, out_tag = 0 after that edge.
REQ-030 SHALL drive in_ready = 1 during and after reset (stall impossible with out_valid = 0); operations presented while rst is high SHALL be discarded.
REQ-031 SHALL discard all in-flight operations on reset mid-operation; no result of a pre-reset operation SHALL appear afterwards.

Verification
REQ-032 Defaults, unsigned, in_a=0xFF, in_b=0xFF, tag=3, out_ready=1 -> out_valid 4 cycles later, out_product=0xFE01, out_tag=3.
REQ-033 Signed: (-128)*(-128) -> 0x4000; (-1)*1 -> 0xFFFF; (-128)*127 -> 0xC080; interleaved back-to-back with unsigned 0x80*0x80 -> 0x4000, each tag matching.
REQ-034 Back-to-back stream of 16 ops, out_ready=1 -> 16 results on 16 consecutive cycles, in order, correct vs. reference model.
REQ-035 Backpressure: drop out_ready for 5 cycles with pipe full -> in_ready=0 for those cycles, out_product stable, no loss or duplication after release.
REQ-036 Reset mid-stream with 3 ops in flight -> out_valid=0 from next edge, none of the 3 results ever appear, new op after reset correct.
REQ-037 Parameter sweep WIDTH/STAGES in {4/1, 8/8, 16/4, 32/8} with random operands, random in_valid/out_ready -> all products match model; latency equals STAGES when unstalled.
